// File: rtl/fetch_stream_unit.sv
// fetch_stream_unit: fetches whole lines from the sysbus into a byte ring
// buffer and presents a WINDOW-byte view at the current PC to the decoder.
module fetch_stream_unit #(
  parameter int BUF_BYTES  = 128,
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 8,
  parameter int WINDOW     = 15,
  parameter int TAG_W      = 13,
  parameter logic [TAG_W-1:0] READ_TAG = TAG_W'(13'h1100)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [63:0]                   entry,
  input  logic                          redirect_valid,
  input  logic [63:0]                   redirect_addr,
  output logic                          bus_reqcyc,
  input  logic                          bus_reqack,
  output logic [63:0]                   bus_req,
  output logic [TAG_W-1:0]              bus_reqtag,
  input  logic                          bus_respcyc,
  output logic                          bus_respack,
  input  logic [BEAT_BYTES*8-1:0]       bus_resp,
  output logic                          win_valid,
  output logic [WINDOW*8-1:0]           win_bytes,
  output logic [63:0]                   win_pc,
  input  logic [$clog2(WINDOW+1)-1:0]   consume
);

  localparam int AW    = $clog2(BUF_BYTES);
  localparam int PW    = AW + 1;
  localparam int BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LOW   = $clog2(LINE_BYTES);
  localparam int BW    = $clog2(BEAT_BYTES);
  localparam int CW    = $clog2(WINDOW + 1);
  localparam logic [63:0] LMASK = ~64'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_ACTIVE, S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_nx;
  logic             r_reqcyc;
  logic [63:0]      r_req;
  logic [BCW-1:0]   r_beat_cnt;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [63:0]      r_pc;
  logic [63:0]      r_line;
  logic [LOW-1:0]   r_skip;
  logic [7:0]       r_buf [BUF_BYTES];

  logic [PW-1:0]    w_occ;
  logic             w_room;
  logic             w_beat;
  logic             w_last;
  logic             w_wr;
  logic             w_adv;
  logic [LOW-1:0]   w_beat_off;
  logic [LOW-1:0]   w_gap;
  logic [BW:0]      w_first;
  logic [BW:0]      w_wcnt;
  logic [AW-1:0]    w_idx [BEAT_BYTES];
  logic             w_ben [BEAT_BYTES];

  assign w_occ       = r_wr_ptr - r_rd_ptr;
  assign w_room      = w_occ <= PW'(BUF_BYTES - LINE_BYTES);
  assign win_valid   = w_occ >= PW'(WINDOW);
  assign win_pc      = r_pc;
  assign bus_reqcyc  = r_reqcyc;
  assign bus_req     = r_req;
  assign bus_reqtag  = READ_TAG;
  assign bus_respack = bus_respcyc;

  assign w_beat = bus_respcyc &&
                  (r_state == S_WAIT || r_state == S_ACTIVE ||
                   r_state == S_DRAIN);
  assign w_last = w_beat && (r_beat_cnt == BCW'(BEATS - 1));
  assign w_wr   = bus_respcyc && !redirect_valid &&
                  (r_state == S_WAIT || r_state == S_ACTIVE);

  // Skipped bytes always form a prefix of the beat, so the kept ones
  // pack contiguously starting at wr_ptr.
  assign w_beat_off = LOW'(r_beat_cnt) * LOW'(BEAT_BYTES);
  assign w_gap      = r_skip - w_beat_off;
  assign w_wcnt     = (BW+1)'(BEAT_BYTES) - w_first;

  always_comb begin
    w_first = '0;
    if (r_skip > w_beat_off)
      w_first = (w_gap >= LOW'(BEAT_BYTES)) ?
                (BW+1)'(BEAT_BYTES) : (BW+1)'(w_gap);
  end

  always_comb begin
    for (int j = 0; j < BEAT_BYTES; j++) begin
      w_idx[j] = AW'(r_wr_ptr + PW'(j) - PW'(w_first));
      w_ben[j] = w_wr && ((BW+1)'(j) >= w_first);
    end
  end

  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < WINDOW; i++)
      win_bytes[i*8 +: 8] = r_buf[AW'(r_rd_ptr + PW'(i))];
  end

  always_comb begin
    w_nx  = r_state;
    w_adv = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (!redirect_valid && w_room) w_nx = S_REQ;
      S_REQ:
        if (redirect_valid) w_nx = bus_reqack ? S_DRAIN : S_IDLE;
        else if (bus_reqack) w_nx = S_WAIT;
      S_WAIT, S_ACTIVE:
        if (w_last) begin
          w_nx  = S_IDLE;
          w_adv = !redirect_valid;
        end else if (redirect_valid) begin
          w_nx = S_DRAIN;
        end else if (bus_respcyc) begin
          w_nx = S_ACTIVE;
        end
      S_DRAIN:
        if (w_last) w_nx = S_IDLE;
      default:
        w_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_reqcyc   <= 1'b0;
      r_req      <= '0;
      r_beat_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pc       <= entry;
      r_line     <= entry & LMASK;
      r_skip     <= entry[LOW-1:0];
    end else begin
      r_state  <= w_nx;
      r_reqcyc <= (w_nx == S_REQ);
      if (r_state == S_IDLE && w_nx == S_REQ) r_req <= r_line;
      if (w_beat) r_beat_cnt <= w_last ? '0 : r_beat_cnt + BCW'(1);
      if (redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_pc     <= redirect_addr;
        r_line   <= redirect_addr & LMASK;
        r_skip   <= redirect_addr[LOW-1:0];
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(w_wcnt);
        if (consume != '0) begin
          r_rd_ptr <= r_rd_ptr + PW'(consume);
          r_pc     <= r_pc + 64'(consume);
        end
        if (w_adv) begin
          r_line <= r_line + 64'(LINE_BYTES);
          r_skip <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_BYTES; i++) r_buf[i] <= '0;
    end else begin
      for (int j = 0; j < BEAT_BYTES; j++)
        if (w_ben[j]) r_buf[w_idx[j]] <= bus_resp[j*8 +: 8];
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    (!redirect_valid && consume != '0) |->
      (win_valid && consume <= CW'(WINDOW)));

endmodule
